// File: rtl/mem_rmw_arbiter.sv
// mem_rmw_arbiter
// Access controller in front of the dual-read/single-write data BRAM.
// - Shares the memory between the CPU load/store path and the debug unit.
// - Turns byte/halfword stores into read-modify-write sequences using the
//   BRAM's second (posedge) read port.
// - Extracts sub-word loads with sign/zero extension.
// - Rejects misaligned CPU accesses.
// Optional feature macro: MEM_ARB_RR_EN. When defined, simultaneous requests
// alternate between the two requesters. When undefined, debug always wins.
module mem_rmw_arbiter #(
  parameter int NB_DATA = 32,
  parameter int N_WORDS = 16,
  parameter int NB_ADDR = $clog2(N_WORDS)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [NB_ADDR+1:0] i_cpu_addr,
  input  logic [1:0]         i_cpu_size,
  input  logic               i_cpu_unsigned,
  input  logic [NB_DATA-1:0] i_cpu_wdata,
  output logic [NB_DATA-1:0] o_cpu_rdata,
  output logic               o_cpu_ack,
  output logic               o_cpu_misaligned,
  input  logic               i_dbg_req,
  input  logic               i_dbg_we,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  output logic               o_dbg_ack,
  output logic [NB_ADDR-1:0] o_mem_r_addr,
  output logic               o_mem_r_en,
  input  logic [NB_DATA-1:0] i_mem_r_data,
  output logic [NB_ADDR-1:0] o_mem_r2_addr,
  output logic               o_mem_r2_en,
  input  logic [NB_DATA-1:0] i_mem_r2_data,
  output logic [NB_ADDR-1:0] o_mem_w_addr,
  output logic [NB_DATA-1:0] o_mem_w_data,
  output logic               o_mem_w_en,
  output logic               o_busy
);

  localparam int EXT_B = NB_DATA - 8;
  localparam int EXT_H = NB_DATA - 16;

  typedef enum logic [2:0] {IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP} state_t;

  state_t             state, state_next;
  logic               any_req, pick_dbg, cpu_misaligned;
  logic               gnt_dbg, cmd_unsigned, cmd_err;
  logic [1:0]         cmd_size;
  logic [NB_ADDR+1:0] cmd_addr;
  logic [NB_ADDR-1:0] cmd_word;
  logic [NB_DATA-1:0] cmd_wdata, merged, load_ext;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  assign any_req  = i_cpu_req | i_dbg_req;
  assign cmd_word = cmd_addr[NB_ADDR+1:2];

  // Halfwords must sit on even bytes, words on 4-byte boundaries.
  assign cpu_misaligned = ((i_cpu_size == 2'b01) && i_cpu_addr[0]) ||
                          (i_cpu_size[1] && (i_cpu_addr[1:0] != 2'b00));

`ifdef MEM_ARB_RR_EN
  logic rr_last_cpu;

  // On a tie, grant whichever requester was not granted last.
  always_comb begin
    pick_dbg = i_dbg_req && (!i_cpu_req || rr_last_cpu);
  end

  // Remember who got the most recent grant; reset as CPU so debug wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_last_cpu <= 1'b1;
    end else if (state == IDLE && any_req) begin
      rr_last_cpu <= !pick_dbg;
    end
  end
`else
  // Debug has fixed priority over the CPU.
  always_comb begin
    pick_dbg = i_dbg_req;
  end
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and all BRAM / handshake outputs; enables are masked during reset.
  always_comb begin
    state_next       = state;
    o_mem_r_en       = 1'b0;
    o_mem_r_addr     = '0;
    o_mem_r2_en      = 1'b0;
    o_mem_r2_addr    = '0;
    o_mem_w_en       = 1'b0;
    o_mem_w_addr     = '0;
    o_mem_w_data     = '0;
    o_cpu_ack        = 1'b0;
    o_dbg_ack        = 1'b0;
    o_cpu_misaligned = 1'b0;
    o_busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          if (pick_dbg) begin
            state_next = i_dbg_we ? WRITE : READ;
          end else if (cpu_misaligned) begin
            state_next = RESP;
          end else if (!i_cpu_we) begin
            state_next = READ;
          end else if (i_cpu_size[1]) begin
            state_next = WRITE;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      READ: begin
        o_mem_r_en   = !i_reset;
        o_mem_r_addr = cmd_word;
        state_next   = RESP;
      end
      RMW_RD: begin
        o_mem_r2_en   = !i_reset;
        o_mem_r2_addr = cmd_word;
        state_next    = RMW_WR;
      end
      RMW_WR: begin
        o_mem_w_en   = !i_reset;
        o_mem_w_addr = cmd_word;
        o_mem_w_data = merged;
        state_next   = RESP;
      end
      WRITE: begin
        o_mem_w_en   = !i_reset;
        o_mem_w_addr = cmd_word;
        o_mem_w_data = cmd_wdata;
        state_next   = RESP;
      end
      RESP: begin
        o_dbg_ack        = gnt_dbg;
        o_cpu_ack        = !gnt_dbg;
        o_cpu_misaligned = !gnt_dbg && cmd_err;
        state_next       = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Replace the addressed byte or halfword lane of the old word with the store data.
  always_comb begin
    merged = i_mem_r2_data;
    if (cmd_size == 2'b00) begin
      merged[8*cmd_addr[1:0] +: 8] = cmd_wdata[7:0];
    end else begin
      merged[16*cmd_addr[1] +: 16] = cmd_wdata[15:0];
    end
  end

  // Pick the addressed lane of the read word and extend it to full width.
  always_comb begin
    byte_sel = i_mem_r_data[8*cmd_addr[1:0] +: 8];
    half_sel = i_mem_r_data[16*cmd_addr[1] +: 16];
    case (cmd_size)
      2'b00:   load_ext = cmd_unsigned ? {{EXT_B{1'b0}}, byte_sel}
                                       : {{EXT_B{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = cmd_unsigned ? {{EXT_H{1'b0}}, half_sel}
                                       : {{EXT_H{half_sel[15]}}, half_sel};
      default: load_ext = i_mem_r_data;
    endcase
  end

  // Latch the granted command in IDLE; capture read data as READ ends.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gnt_dbg      <= 1'b0;
      cmd_addr     <= '0;
      cmd_size     <= 2'b00;
      cmd_unsigned <= 1'b0;
      cmd_wdata    <= '0;
      cmd_err      <= 1'b0;
      o_cpu_rdata  <= '0;
      o_dbg_rdata  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_dbg <= pick_dbg;
        if (pick_dbg) begin
          cmd_addr     <= {i_dbg_addr, 2'b00};
          cmd_size     <= 2'b10;
          cmd_unsigned <= 1'b0;
          cmd_wdata    <= i_dbg_wdata;
          cmd_err      <= 1'b0;
        end else begin
          cmd_addr     <= i_cpu_addr;
          cmd_size     <= i_cpu_size;
          cmd_unsigned <= i_cpu_unsigned;
          cmd_wdata    <= i_cpu_wdata;
          cmd_err      <= cpu_misaligned;
        end
      end
      if (state == READ) begin
        if (gnt_dbg) begin
          o_dbg_rdata <= i_mem_r_data;
        end else begin
          o_cpu_rdata <= load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rmw_arbiter.sv
// Testbench for mem_rmw_arbiter: BRAM model plus scoreboard of expected
// completions (requester, latency, misaligned flag, read data).
module tb_mem_rmw_arbiter;

  localparam int NB_DATA = 32;
  localparam int N_WORDS = 16;
  localparam int NB_ADDR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_reset;
  logic               i_cpu_req, i_cpu_we, i_cpu_unsigned;
  logic [NB_ADDR+1:0] i_cpu_addr;
  logic [1:0]         i_cpu_size;
  logic [NB_DATA-1:0] i_cpu_wdata, o_cpu_rdata;
  logic               o_cpu_ack, o_cpu_misaligned;
  logic               i_dbg_req, i_dbg_we;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic [NB_DATA-1:0] i_dbg_wdata, o_dbg_rdata;
  logic               o_dbg_ack;
  logic [NB_ADDR-1:0] o_mem_r_addr, o_mem_r2_addr, o_mem_w_addr;
  logic               o_mem_r_en, o_mem_r2_en, o_mem_w_en, o_busy;
  logic [NB_DATA-1:0] mem_r_data, mem_r2_data, o_mem_w_data;

  mem_rmw_arbiter #(.NB_DATA(NB_DATA), .N_WORDS(N_WORDS)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_size(i_cpu_size), .i_cpu_unsigned(i_cpu_unsigned),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_rdata(o_cpu_rdata), .o_cpu_ack(o_cpu_ack),
    .o_cpu_misaligned(o_cpu_misaligned),
    .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_rdata(o_dbg_rdata), .o_dbg_ack(o_dbg_ack),
    .o_mem_r_addr(o_mem_r_addr), .o_mem_r_en(o_mem_r_en), .i_mem_r_data(mem_r_data),
    .o_mem_r2_addr(o_mem_r2_addr), .o_mem_r2_en(o_mem_r2_en), .i_mem_r2_data(mem_r2_data),
    .o_mem_w_addr(o_mem_w_addr), .o_mem_w_data(o_mem_w_data), .o_mem_w_en(o_mem_w_en),
    .o_busy(o_busy)
  );

  typedef struct {
    logic        dbg;
    logic        mis;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   en_cnt = 0;
  int   r2_cyc = -1;
  int   w_cyc = -1;
  logic [31:0] w_seen = '0;
  logic [31:0] mem [N_WORDS];

  logic [114:0] all_outs;
  assign all_outs = {o_cpu_rdata, o_cpu_ack, o_cpu_misaligned, o_dbg_rdata, o_dbg_ack,
                     o_mem_r_addr, o_mem_r_en, o_mem_r2_addr, o_mem_r2_en,
                     o_mem_w_addr, o_mem_w_data, o_mem_w_en, o_busy};

  // Cycle counter: cycle 0 of a transaction is the IDLE cycle that sees the request.
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: read port 1 and write port act on negedge, read port 2 on posedge.
  always @(negedge clk) begin
    if (o_mem_r_en) mem_r_data <= mem[o_mem_r_addr];
    if (o_mem_w_en) begin
      mem[o_mem_w_addr] <= o_mem_w_data;
      w_cyc  <= cyc;
      w_seen <= o_mem_w_data;
    end
    if (o_mem_r2_en) r2_cyc <= cyc;
    if (o_mem_r_en || o_mem_r2_en || o_mem_w_en) en_cnt <= en_cnt + 1;
  end

  always @(posedge clk) begin
    if (o_mem_r2_en) mem_r2_data <= mem[o_mem_r2_addr];
  end

  task automatic drive_cpu(input logic we, input logic [5:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd);
    @(posedge clk); #1;
    i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_addr = addr; i_cpu_size = size;
    i_cpu_unsigned = uns; i_cpu_wdata = wd;
    t_start = cyc;
  endtask

  task automatic drive_dbg(input logic we, input logic [3:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    i_dbg_req = 1'b1; i_dbg_we = we; i_dbg_addr = addr; i_dbg_wdata = wd;
    t_start = cyc;
  endtask

  // Waits (bounded) for either ack; lat = -1 if none arrives.
  task automatic run_until_ack(output logic sd, output logic sc, output logic sm, output int lat);
    sd = 1'b0; sc = 1'b0; sm = 1'b0; lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_dbg_ack || o_cpu_ack) begin
        sd = o_dbg_ack; sc = o_cpu_ack; sm = o_cpu_misaligned; lat = cyc - t_start;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h, required 0", all_outs);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_dbg_word();
    exp_t e;
    logic sd, sc, sm;
    int lat;
    for (int i = 0; i < 2; i++) begin
      e.dbg = 1'b1; e.mis = 1'b0; e.rdata = 32'hDEADBEEF; e.lat = 2;
      exp_q.push_back(e);
      drive_dbg(i == 0, 4'd3, 32'hDEADBEEF);
      run_until_ack(sd, sc, sm, lat);
      i_dbg_req = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({sd, sc, sm} !== {e.dbg, !e.dbg, e.mis} || lat != e.lat) begin
        failures++;
        $display("[TB] FAIL dbg_word%0d ack: dbg,cpu,mis=%b%b%b at %0d, required %b%b%b at %0d",
                 i, sd, sc, sm, lat, e.dbg, !e.dbg, e.mis, e.lat);
      end
      if (i == 1) begin
        checks++;
        if (o_dbg_rdata !== e.rdata) begin
          failures++;
          $display("[TB] FAIL dbg_word_rdata: got %h, required %h", o_dbg_rdata, e.rdata);
        end
      end
    end
  endtask

  // Stores: byte into DEADBEEF, half into a zero word, aligned word.
  logic [5:0]  st_addr [3] = '{6'h0D, 6'h14, 6'h10};
  logic [1:0]  st_size [3] = '{2'b00, 2'b01, 2'b10};
  logic [31:0] st_wd   [3] = '{32'h000000AA, 32'h0000BEEF, 32'h80000001};
  logic [31:0] st_mem  [3] = '{32'hDEADAAEF, 32'h0000BEEF, 32'h80000001};
  int          st_lat  [3] = '{3, 3, 2};

  task automatic test_stores();
    exp_t e;
    logic sd, sc, sm;
    int lat, t0;
    for (int i = 0; i < 3; i++) begin
      e.dbg = 1'b0; e.mis = 1'b0; e.rdata = '0; e.lat = st_lat[i];
      exp_q.push_back(e);
      drive_cpu(1'b1, st_addr[i], st_size[i], 1'b0, st_wd[i]);
      t0 = t_start;
      run_until_ack(sd, sc, sm, lat);
      i_cpu_req = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({sd, sc, sm} !== {e.dbg, !e.dbg, e.mis} || lat != e.lat) begin
        failures++;
        $display("[TB] FAIL store%0d ack: dbg,cpu,mis=%b%b%b at %0d, required %b%b%b at %0d",
                 i, sd, sc, sm, lat, e.dbg, !e.dbg, e.mis, e.lat);
      end
      checks++;
      if (w_cyc != t0 + e.lat - 1 || w_seen !== st_mem[i]) begin
        failures++;
        $display("[TB] FAIL store%0d write: %h at cycle %0d, required %h at cycle %0d",
                 i, w_seen, w_cyc - t0, st_mem[i], e.lat - 1);
      end
      if (st_size[i] != 2'b10) begin
        checks++;
        if (r2_cyc != t0 + 1) begin
          failures++;
          $display("[TB] FAIL store%0d r2_en: cycle %0d, required 1", i, r2_cyc - t0);
        end
      end
    end
  endtask

  logic [5:0]  ld_addr [10] = '{6'h0D, 6'h0D, 6'h0E, 6'h0F, 6'h14, 6'h14, 6'h13, 6'h12, 6'h10, 6'h0C};
  logic [1:0]  ld_size [10] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
  logic        ld_uns  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] ld_exp  [10] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFDEAD, 32'hFFFFFFDE,
                                32'h0000BEEF, 32'hFFFFBEEF, 32'hFFFFFF80, 32'h00008000,
                                32'h80000001, 32'hDEADAAEF};

  task automatic test_loads();
    exp_t e;
    logic sd, sc, sm;
    int lat;
    for (int i = 0; i < 10; i++) begin
      e.dbg = 1'b0; e.mis = 1'b0; e.rdata = ld_exp[i]; e.lat = 2;
      exp_q.push_back(e);
      drive_cpu(1'b0, ld_addr[i], ld_size[i], ld_uns[i], 32'h0);
      run_until_ack(sd, sc, sm, lat);
      i_cpu_req = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({sd, sc, sm} !== {e.dbg, !e.dbg, e.mis} || lat != e.lat || o_cpu_rdata !== e.rdata) begin
        failures++;
        $display("[TB] FAIL load%0d: dbg,cpu,mis=%b%b%b at %0d data %h, required %b%b%b at %0d data %h",
                 i, sd, sc, sm, lat, o_cpu_rdata, e.dbg, !e.dbg, e.mis, e.lat, e.rdata);
      end
    end
  endtask

  logic [5:0] ma_addr [4] = '{6'h06, 6'h0D, 6'h03, 6'h0E};
  logic [1:0] ma_size [4] = '{2'b10, 2'b01, 2'b01, 2'b11};
  logic       ma_we   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_misaligned();
    exp_t e;
    logic sd, sc, sm;
    int lat, en0;
    for (int i = 0; i < 4; i++) begin
      e.dbg = 1'b0; e.mis = 1'b1; e.rdata = '0; e.lat = 1;
      exp_q.push_back(e);
      en0 = en_cnt;
      drive_cpu(ma_we[i], ma_addr[i], ma_size[i], 1'b0, 32'h12345678);
      run_until_ack(sd, sc, sm, lat);
      i_cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({sd, sc, sm} !== {e.dbg, !e.dbg, e.mis} || lat != e.lat || en_cnt != en0) begin
        failures++;
        $display("[TB] FAIL misaligned%0d: dbg,cpu,mis=%b%b%b at %0d enables %0d, required %b%b%b at %0d enables 0",
                 i, sd, sc, sm, lat, en_cnt - en0, e.dbg, !e.dbg, e.mis, e.lat);
      end
    end
  endtask

  // Both requesters held for three transactions right after reset.
  task automatic test_back_to_back();
    exp_t e;
    logic sd, sc, sm;
    int lat;
    logic [31:0] got;
`ifdef MEM_ARB_RR_EN
    logic order [3] = '{1'b1, 1'b0, 1'b1};
`else
    logic order [3] = '{1'b1, 1'b1, 1'b1};
`endif
    @(posedge clk); #1;
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.dbg = order[i]; e.mis = 1'b0; e.rdata = 32'hDEADAAEF; e.lat = 2;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 4'd3;
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 6'h0C; i_cpu_size = 2'b10; i_cpu_unsigned = 1'b0;
    t_start = cyc;
    for (int i = 0; i < 3; i++) begin
      run_until_ack(sd, sc, sm, lat);
      t_start = cyc + 1;
      e = exp_q.pop_front();
      got = e.dbg ? o_dbg_rdata : o_cpu_rdata;
      checks++;
      if ({sd, sc, sm} !== {e.dbg, !e.dbg, e.mis} || lat != e.lat || got !== e.rdata) begin
        failures++;
        $display("[TB] FAIL arb%0d: dbg,cpu,mis=%b%b%b at %0d data %h, required %b%b%b at %0d data %h",
                 i, sd, sc, sm, lat, got, e.dbg, !e.dbg, e.mis, e.lat, e.rdata);
      end
    end
    i_dbg_req = 1'b0;
    i_cpu_req = 1'b0;
  endtask

  task automatic test_reset_in_rmw();
    exp_t e;
    logic sd, sc, sm;
    int lat;
    drive_cpu(1'b1, 6'h0C, 2'b00, 1'b0, 32'h00000055);
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b1 || o_mem_w_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rmw_wr_reached: busy=%b w_en=%b, required 1 1", o_busy, o_mem_w_en);
    end
    i_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_mem_w_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_w_en: got %b, required 0", o_mem_w_en);
    end
    @(posedge clk); #1;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_rmw_outputs: got %h, required 0", all_outs);
    end
    i_reset = 1'b0;
    i_cpu_req = 1'b0;
    e.dbg = 1'b1; e.mis = 1'b0; e.rdata = 32'hDEADAAEF; e.lat = 2;
    exp_q.push_back(e);
    drive_dbg(1'b0, 4'd3, 32'h0);
    run_until_ack(sd, sc, sm, lat);
    i_dbg_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({sd, sc} !== {e.dbg, !e.dbg} || lat != e.lat || o_dbg_rdata !== e.rdata) begin
      failures++;
      $display("[TB] FAIL reset_rmw_word: dbg,cpu=%b%b at %0d data %h, required %b%b at %0d data %h",
               sd, sc, lat, o_dbg_rdata, e.dbg, !e.dbg, e.lat, e.rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < N_WORDS; i++) mem[i] = '0;
    mem_r_data = '0; mem_r2_data = '0;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_size = 2'b00;
    i_cpu_unsigned = 1'b0; i_cpu_wdata = '0;
    i_dbg_req = 1'b0; i_dbg_we = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
    test_reset();
    test_dbg_word();
    test_stores();
    test_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_in_rmw();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
